// File: rtl/pps_pkg.sv
// Shared definitions for the PPS conditioner: FSM state encoding and counter sizing.
package pps_pkg;

  localparam logic [1:0] HUNT = 2'd0;
  localparam logic [1:0] ACQ  = 2'd1;
  localparam logic [1:0] LOCK = 2'd2;

  // Bits needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pps_conditioner_edge.sv
// Synchronises the raw PPS pin and emits one qedge strobe per high phase that
// stays high for at least MIN_HIGH synced cycles.
module pps_edge_qualifier
  import pps_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic qedge
);

  localparam int RW = cnt_width(MIN_HIGH);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [RW-1:0]          run_reg;
  logic                   qedge_reg;
  logic                   s;

  assign s     = sync_reg[SYNC_STAGES-1];
  assign qedge = qedge_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= '0;
      run_reg   <= '0;
      qedge_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin};
      if (!s) begin
        run_reg <= '0;
      end else if (run_reg != RW'(MIN_HIGH)) begin
        run_reg <= run_reg + RW'(1);
      end
      // Strobe on the cycle the run saturates; the counter then sits at MIN_HIGH.
      qedge_reg <= s && (run_reg == RW'(MIN_HIGH - 1));
    end
  end

endmodule

// File: rtl/pps_conditioner.sv
// Cleans the external PPS pin: qualifies edges, measures the period, locks after
// LOCK_COUNT in-window periods and emits a fixed-width pulse only while locked.
module pps_conditioner
  import pps_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_HIGH     = 4,
  parameter int CLKS_PER_SEC = 200,
  parameter int TOL          = 4,
  parameter int LOCK_COUNT   = 3,
  parameter int PULSE_LEN    = 100,
  localparam int CW          = cnt_width(CLKS_PER_SEC + TOL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pps_in,
  output logic          pps_out,
  output logic          locked,
  output logic          missed,
  output logic [CW-1:0] period
);

  localparam int GW = cnt_width(LOCK_COUNT);
  localparam int TW = cnt_width(PULSE_LEN);
  localparam logic [CW-1:0] PC_MAX = CW'(CLKS_PER_SEC + TOL);
  localparam logic [CW-1:0] WIN_LO = CW'(CLKS_PER_SEC - TOL);

  logic          qedge;
  logic [CW-1:0] pc_reg;
  logic [CW-1:0] period_reg;
  logic [1:0]    state_reg, state_next;
  logic [GW-1:0] good_reg, good_next;
  logic [TW-1:0] timer_reg;
  logic          locked_reg;
  logic          missed_reg;
  logic          in_win;
  logic          timeout;
  logic          fire;
  logic          miss_set;

  pps_edge_qualifier #(
    .SYNC_STAGES(SYNC_STAGES),
    .MIN_HIGH   (MIN_HIGH)
  ) u_edge (
    .clk  (clk),
    .rst  (rst),
    .pin  (pps_in),
    .qedge(qedge)
  );

  assign in_win  = (pc_reg >= WIN_LO) && (pc_reg <= PC_MAX);
  // A qedge landing on the saturation cycle is an in-window edge, not a timeout.
  assign timeout = (pc_reg == PC_MAX) && !qedge;

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    fire       = 1'b0;
    miss_set   = 1'b0;
    case (state_reg)
      HUNT: begin
        if (qedge) begin
          state_next = ACQ;
          good_next  = '0;
        end
      end
      ACQ: begin
        if (qedge) begin
          if (!in_win) begin
            good_next = '0;
          end else if (good_reg == GW'(LOCK_COUNT - 1)) begin
            state_next = LOCK;
            good_next  = '0;
            fire       = 1'b1;
          end else begin
            good_next = good_reg + GW'(1);
          end
        end else if (timeout) begin
          state_next = HUNT;
          good_next  = '0;
          miss_set   = 1'b1;
        end
      end
      LOCK: begin
        if (qedge) begin
          if (in_win) begin
            fire = 1'b1;
          end else begin
            state_next = ACQ;
            good_next  = '0;
          end
        end else if (timeout) begin
          state_next = HUNT;
          good_next  = '0;
          miss_set   = 1'b1;
        end
      end
      default: begin
        state_next = HUNT;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= '0;
      period_reg <= '0;
      state_reg  <= HUNT;
      good_reg   <= '0;
      timer_reg  <= '0;
      locked_reg <= 1'b0;
      missed_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      good_reg   <= good_next;
      locked_reg <= (state_reg == LOCK);
      missed_reg <= missed_reg | miss_set;
      if (qedge) begin
        pc_reg <= CW'(1);
      end else if (pc_reg != PC_MAX) begin
        pc_reg <= pc_reg + CW'(1);
      end
      if (qedge && (state_reg != HUNT)) begin
        period_reg <= pc_reg;
      end
      // The timer runs out independently of the FSM, so leaving LOCK never truncates a pulse.
      if (fire) begin
        timer_reg <= TW'(PULSE_LEN);
      end else if (timer_reg != '0) begin
        timer_reg <= timer_reg - TW'(1);
      end
    end
  end

  assign pps_out = (timer_reg != '0);
  assign locked  = locked_reg;
  assign missed  = missed_reg;
  assign period  = period_reg;

endmodule
